serial_multiplier: RTL and testbench

8-bit signed (two's-complement) shift-add multiplier with an internal control FSM and a 4-digit multiplexed hex display driver. One operand is preloaded into register B from the switches. The other is read live from the switches as S when Run is pressed. The 16-bit product appears in {A,B}, with sign-extension bit X. It is the top level of the multiplier lab design: switches and buttons in, LED/seven-segment outputs and debug values out.

---
 rtl/serial_multiplier.sv | 153 +++++++++++++++
 tb/tb_serial_multiplier.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_multiplier.sv
// 8x8 signed shift-add multiplier with control FSM and a 4-digit multiplexed hex display.
// {A,B} holds the 16-bit product; X is the sign-extension bit above A.
module serial_multiplier #(
  parameter int unsigned SCAN_BITS = 16
) (
  input  logic       Clk,
  input  logic       Reset_Load_Clear,
  input  logic [7:0] SW,
  input  logic       Run,
  output logic [3:0] hex_grid,
  output logic [7:0] hex_seg,
  output logic [7:0] Aval,
  output logic [7:0] Bval,
  output logic       Xval
);

  typedef enum logic [4:0] {
    StIdle, StClr,
    StAdd0, StSh0, StAdd1, StSh1, StAdd2, StSh2, StAdd3, StSh3,
    StAdd4, StSh4, StAdd5, StSh5, StAdd6, StSh6,
    StSub7, StSh7,
    StDone
  } state_e;

  localparam logic [SCAN_BITS-1:0] ScanOne = 1;

  state_e               state_q, state_d;
  logic [7:0]           a_q, a_d;
  logic [7:0]           b_q, b_d;
  logic                 x_q, x_d;
  logic [SCAN_BITS-1:0] scan_q, scan_d;

  logic Shift, Clr_Ld, Add, Sub, M;

  logic [8:0] a_ext, s_ext;
  logic [1:0] digit;
  logic [3:0] nibble;
  logic [6:0] seg_n;

  assign M     = b_q[0];
  assign a_ext = {a_q[7], a_q};
  assign s_ext = {SW[7], SW};

  // Operation states are laid out consecutively, so the sequence is a simple increment.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (Run) state_d = StClr;
      StDone:  if (!Run) state_d = StIdle;
      default: begin
        if (state_q > StDone) state_d = StIdle;
        else                  state_d = state_e'(state_q + 5'd1);
      end
    endcase
  end

  always_comb begin
    Clr_Ld = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    unique case (state_q)
      StClr: Clr_Ld = 1'b1;
      StAdd0, StAdd1, StAdd2, StAdd3, StAdd4, StAdd5, StAdd6: Add = 1'b1;
      StSub7: Sub = 1'b1;
      StSh0, StSh1, StSh2, StSh3, StSh4, StSh5, StSh6, StSh7: Shift = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    a_d = a_q;
    x_d = x_q;
    b_d = b_q;
    if (Clr_Ld) begin
      a_d = 8'h00;
      x_d = 1'b0;
    end else if (Add && M) begin
      {x_d, a_d} = a_ext + s_ext;
    end else if (Sub && M) begin
      {x_d, a_d} = a_ext - s_ext;
    end else if (Shift) begin
      a_d = {x_q, a_q[7:1]};
      b_d = {a_q[0], b_q[7:1]};
    end
    // B has no async reset: it loads the switches on every edge while reset is held.
    if (!Reset_Load_Clear) b_d = SW;
  end

  assign scan_d = scan_q + ScanOne;

  always_ff @(posedge Clk or negedge Reset_Load_Clear) begin
    if (!Reset_Load_Clear) begin
      state_q <= StIdle;
      a_q     <= 8'h00;
      x_q     <= 1'b0;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      scan_q  <= scan_d;
    end
  end

  always_ff @(posedge Clk) begin
    b_q <= b_d;
  end

  assign digit = scan_q[SCAN_BITS-1 -: 2];

  always_comb begin
    hex_grid = 4'b1111;
    nibble   = b_q[3:0];
    unique case (digit)
      2'd0: begin hex_grid = 4'b1110; nibble = b_q[3:0]; end
      2'd1: begin hex_grid = 4'b1101; nibble = b_q[7:4]; end
      2'd2: begin hex_grid = 4'b1011; nibble = a_q[3:0]; end
      2'd3: begin hex_grid = 4'b0111; nibble = a_q[7:4]; end
      default: ;
    endcase
  end

  // Active-low g..a patterns.
  always_comb begin
    seg_n = 7'b1111111;
    unique case (nibble)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      4'hF: seg_n = 7'b0001110;
      default: ;
    endcase
  end

  assign hex_seg = {1'b1, seg_n};
  assign Aval    = a_q;
  assign Bval    = b_q;
  assign Xval    = x_q;

endmodule

// File: tb/tb_serial_multiplier.sv
// Self-checking bench for serial_multiplier: signed products against integer arithmetic,
// reset/abort behaviour, control-signal trace and display scanning.
module tb_serial_multiplier;

  localparam int unsigned ScanBits = 4;

  logic       Clk = 1'b0;
  logic       Reset_Load_Clear;
  logic [7:0] SW;
  logic       Run;
  logic [3:0] hex_grid;
  logic [7:0] hex_seg;
  logic [7:0] Aval, Bval;
  logic       Xval;

  int checks   = 0;
  int failures = 0;

  logic [ScanBits-1:0] scan_model;

  serial_multiplier #(.SCAN_BITS(ScanBits)) dut (
    .Clk             (Clk),
    .Reset_Load_Clear(Reset_Load_Clear),
    .SW              (SW),
    .Run             (Run),
    .hex_grid        (hex_grid),
    .hex_seg         (hex_seg),
    .Aval            (Aval),
    .Bval            (Bval),
    .Xval            (Xval)
  );

  always #5 Clk = ~Clk;

  // Display scan reference: clears in reset, counts every clock otherwise.
  always @(posedge Clk or negedge Reset_Load_Clear) begin
    if (!Reset_Load_Clear) scan_model <= '0;
    else                   scan_model <= scan_model + 1'b1;
  end

  function automatic logic [7:0] seg_ref(input logic [3:0] n);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[n];
  endfunction

  function automatic logic [15:0] prod_ref(input logic [7:0] s, input logic [7:0] b);
    int p;
    p = int'($signed(s)) * int'($signed(b));
    return p[15:0];
  endfunction

  task automatic load_b(input logic [7:0] v);
    @(negedge Clk);
    Reset_Load_Clear = 1'b0;
    SW = v;
    @(negedge Clk);
    Reset_Load_Clear = 1'b1;
  endtask

  task automatic run_once(input logic [7:0] s);
    @(negedge Clk);
    SW  = s;
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    repeat (20) @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset_Load_Clear = 1'b0;
    SW  = 8'h5A;
    Run = 1'b0;
    #1;
    checks++;
    if (Aval !== 8'h00 || Xval !== 1'b0) begin
      failures++;
      $display("FAIL reset_ax: got A=%h X=%b expected A=00 X=0", Aval, Xval);
    end
    checks++;
    if ({dut.Clr_Ld, dut.Add, dut.Sub, dut.Shift} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {dut.Clr_Ld, dut.Add, dut.Sub, dut.Shift});
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Bval !== 8'h5A) begin
      failures++;
      $display("FAIL reset_bload: got B=%h expected 5a", Bval);
    end
    checks++;
    if (hex_grid !== 4'b1110 || hex_seg !== seg_ref(4'hA)) begin
      failures++;
      $display("FAIL reset_display: got grid=%b seg=%h expected grid=1110 seg=%h",
               hex_grid, hex_seg, seg_ref(4'hA));
    end
    @(negedge Clk);
    Reset_Load_Clear = 1'b1;
  endtask

  task automatic test_multiply(input string name, input logic [7:0] b0, input logic [7:0] s);
    logic [15:0] e;
    e = prod_ref(s, b0);
    load_b(b0);
    run_once(s);
    checks++;
    if ({Aval, Bval} !== e) begin
      failures++;
      $display("FAIL %s_product: %h*%h got %h expected %h", name, s, b0, {Aval, Bval}, e);
    end
    checks++;
    if (Xval !== e[15]) begin
      failures++;
      $display("FAIL %s_x: got %b expected %b", name, Xval, e[15]);
    end
  endtask

  task automatic test_chain(input logic [7:0] b0, input logic [7:0] s1, input logic [7:0] s2);
    logic [15:0] e1, e2;
    e1 = prod_ref(s1, b0);
    e2 = prod_ref(s2, e1[7:0]);
    load_b(b0);
    run_once(s1);
    checks++;
    if ({Xval, Aval, Bval} !== {e1[15], e1}) begin
      failures++;
      $display("FAIL chain_first: got X=%b %h expected X=%b %h", Xval, {Aval, Bval}, e1[15], e1);
    end
    run_once(s2);
    checks++;
    if ({Xval, Aval, Bval} !== {e2[15], e2}) begin
      failures++;
      $display("FAIL chain_second: got X=%b %h expected X=%b %h", Xval, {Aval, Bval}, e2[15], e2);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      test_multiply("random", 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic test_abort;
    logic [7:0] nsw;
    load_b(8'h6D);
    @(negedge Clk);
    SW  = 8'h93;
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
    repeat (5) @(negedge Clk);
    nsw = 8'($urandom);
    SW  = nsw;
    Reset_Load_Clear = 1'b0;
    #1;
    checks++;
    if (Aval !== 8'h00 || Xval !== 1'b0) begin
      failures++;
      $display("FAIL abort_ax: got A=%h X=%b expected A=00 X=0", Aval, Xval);
    end
    checks++;
    if ({dut.Clr_Ld, dut.Add, dut.Sub, dut.Shift} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_ctrl: got %b expected 0000",
               {dut.Clr_Ld, dut.Add, dut.Sub, dut.Shift});
    end
    @(posedge Clk);
    #1;
    checks++;
    if (Bval !== nsw) begin
      failures++;
      $display("FAIL abort_bload: got B=%h expected %h", Bval, nsw);
    end
    @(negedge Clk);
    Reset_Load_Clear = 1'b1;
    repeat (5) @(negedge Clk);
    checks++;
    if (Aval !== 8'h00 || Bval !== nsw || {dut.Clr_Ld, dut.Add, dut.Sub, dut.Shift} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_idle: got A=%h B=%h expected A=00 B=%h idle", Aval, Bval, nsw);
    end
  endtask

  task automatic test_run_held(input logic [7:0] b0, input logic [7:0] s);
    int n_clr, n_add, n_sub, n_sh, n_multi;
    byte ops[$];
    byte exp_ops[$];
    logic [15:0] e;
    string got_s, exp_s;
    n_clr = 0; n_add = 0; n_sub = 0; n_sh = 0; n_multi = 0;
    e = prod_ref(s, b0);
    exp_ops.push_back("C");
    for (int k = 0; k < 7; k++) begin
      exp_ops.push_back("A");
      exp_ops.push_back("S");
    end
    exp_ops.push_back("B");
    exp_ops.push_back("S");
    load_b(b0);
    @(negedge Clk);
    SW  = s;
    Run = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if ((int'(dut.Clr_Ld) + int'(dut.Add) + int'(dut.Sub) + int'(dut.Shift)) > 1) n_multi++;
      if (dut.Clr_Ld) begin n_clr++; ops.push_back("C"); end
      if (dut.Add)    begin n_add++; ops.push_back("A"); end
      if (dut.Sub)    begin n_sub++; ops.push_back("B"); end
      if (dut.Shift)  begin n_sh++;  ops.push_back("S"); end
    end
    checks++;
    if (n_clr !== 1 || n_add !== 7 || n_sub !== 1 || n_sh !== 8 || n_multi !== 0) begin
      failures++;
      $display("FAIL held_counts: got clr=%0d add=%0d sub=%0d shift=%0d overlap=%0d expected 1/7/1/8/0",
               n_clr, n_add, n_sub, n_sh, n_multi);
    end
    got_s = ""; exp_s = "";
    foreach (ops[i])     got_s = {got_s, string'(ops[i])};
    foreach (exp_ops[i]) exp_s = {exp_s, string'(exp_ops[i])};
    checks++;
    if (got_s != exp_s) begin
      failures++;
      $display("FAIL held_sequence: got %s expected %s", got_s, exp_s);
    end
    checks++;
    if ({Xval, Aval, Bval} !== {e[15], e}) begin
      failures++;
      $display("FAIL held_product: got X=%b %h expected X=%b %h", Xval, {Aval, Bval}, e[15], e);
    end
    Run = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_display;
    logic [15:0] e;
    logic [7:0]  b0, s;
    logic [3:0]  nib, exp_grid;
    int          bad;
    b0 = 8'($urandom);
    s  = 8'($urandom);
    e  = prod_ref(s, b0);
    load_b(b0);
    run_once(s);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      nib      = 4'(e >> (4 * int'(scan_model[ScanBits-1 -: 2])));
      exp_grid = ~(4'b0001 << scan_model[ScanBits-1 -: 2]);
      checks++;
      if (hex_grid !== exp_grid || hex_seg !== seg_ref(nib)) begin
        failures++;
        bad++;
        if (bad < 5)
          $display("FAIL display: cnt=%0d got grid=%b seg=%h expected grid=%b seg=%h",
                   scan_model, hex_grid, hex_seg, exp_grid, seg_ref(nib));
      end
    end
  endtask

  initial begin
    test_reset();
    test_multiply("neg59x7", 8'hC5, 8'h07);
    test_multiply("59xneg7", 8'h3B, 8'hF9);
    test_multiply("m80x80", 8'h80, 8'h80);
    test_multiply("zero_b", 8'h00, 8'($urandom));
    test_multiply("zero_s", 8'($urandom), 8'h00);
    test_multiply("max_pos", 8'h7F, 8'h80);
    test_chain(8'hFF, 8'hFF, 8'hFF);
    test_chain(8'($urandom), 8'($urandom), 8'($urandom));
    test_random(25);
    test_abort();
    test_run_held(8'hC5, 8'h07);
    test_run_held(8'($urandom), 8'($urandom));
    test_display();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
